// File: rtl/cmd_pkg.sv
// Command packet format and shared transmit-frame definitions.
package cmd_pkg;

  localparam int CMD_PKT_W = 48;

  localparam logic [7:0] TX_SOF_DEFAULT = 8'hA5;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  arg;
    logic [31:0] payload;
  } cmd_packet_t;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_SEND    = 3'd1,
    TX_WAIT_HI = 3'd2,
    TX_WAIT_LO = 3'd3,
    TX_GAP     = 3'd4
  } tx_frame_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level handshake between the frame controller and the UART TX core.
interface uart_tx_if;
  logic [7:0] byte_data;
  logic       byte_start;
  logic       byte_busy;

  modport master (output byte_data, output byte_start, input byte_busy);
  modport slave  (input byte_data, input byte_start, output byte_busy);
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// Frames command packets as SOF + payload (MSB first) + optional XOR checksum
// and feeds them byte by byte to the UART TX core.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a packet and an idle core; pops on entry exit
// SEND     | byte_start pulse for the byte held in byte_data
// WAIT_HI  | waiting for the core to raise busy (4-cycle timeout)
// WAIT_LO  | core shifting; on busy fall load next byte or end frame
// GAP      | inter-frame idle time, no FIFO pops
module uart_tx_frame_ctrl
  import cmd_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE   = TX_SOF_DEFAULT,
  parameter int         GAP_CYCLES = 16,
  parameter bit         CHK_EN     = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  cmd_packet_t   cmd_fifo_rd_data,
  input  logic          cmd_fifo_valid,
  output logic          cmd_fifo_rd_en,
  uart_tx_if.master     tx,
  output logic          busy,
  output logic [15:0]   frames_sent
);

  localparam int N_BYTES = CMD_PKT_W / 8;
  localparam int IDX_W   = $clog2(N_BYTES + 2);
  localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  // Byte index 0 is SOF; payload bytes are 1..N_BYTES; checksum follows.
  localparam logic [IDX_W-1:0] PAY_END  = IDX_W'(N_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHK_EN ? N_BYTES + 1 : N_BYTES);

  localparam logic [2:0] S_IDLE    = TX_IDLE;
  localparam logic [2:0] S_SEND    = TX_SEND;
  localparam logic [2:0] S_WAIT_HI = TX_WAIT_HI;
  localparam logic [2:0] S_WAIT_LO = TX_WAIT_LO;
  localparam logic [2:0] S_GAP     = TX_GAP;

  logic [2:0]           state;
  logic [CMD_PKT_W-1:0] shreg;
  logic [IDX_W-1:0]     idx;
  logic [7:0]           chk;
  logic [GAP_W-1:0]     gap_cnt;
  logic [1:0]           tmo;
  logic                 byte_done;
  logic                 last_byte;

  // Pop only from an idle controller with an idle core; held low in reset.
  assign cmd_fifo_rd_en = rst_n & (state == S_IDLE) & cmd_fifo_valid & ~tx.byte_busy;
  assign tx.byte_start  = (state == S_SEND);
  assign busy           = (state != S_IDLE);

  // A byte is finished when busy falls, or when busy never rose within the timeout.
  assign byte_done = ~tx.byte_busy &
                     ((state == S_WAIT_LO) | ((state == S_WAIT_HI) & (tmo == 2'd0)));
  assign last_byte = (idx == LAST_IDX);

  // Frame sequencing, byte loading and checksum accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      shreg        <= '0;
      idx          <= '0;
      chk          <= '0;
      gap_cnt      <= '0;
      tmo          <= '0;
      tx.byte_data <= '0;
      frames_sent  <= '0;
    end else if (byte_done) begin
      if (last_byte) begin
        frames_sent <= frames_sent + 16'd1;
        if (GAP_CYCLES == 0) begin
          state <= S_IDLE;
        end else begin
          gap_cnt <= GAP_W'(GAP_CYCLES);
          state   <= S_GAP;
        end
      end else begin
        idx <= idx + 1'b1;
        if (idx < PAY_END) begin
          tx.byte_data <= shreg[CMD_PKT_W-1 -: 8];
          chk          <= chk ^ shreg[CMD_PKT_W-1 -: 8];
          shreg        <= shreg << 8;
        end else begin
          tx.byte_data <= chk;
        end
        state <= S_SEND;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fifo_rd_en) begin
            shreg        <= cmd_fifo_rd_data;
            idx          <= '0;
            chk          <= '0;
            tx.byte_data <= SOF_BYTE;
            state        <= S_SEND;
          end
        end
        S_SEND: begin
          tmo   <= 2'd3;
          state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (tx.byte_busy) state <= S_WAIT_LO;
          else              tmo   <= tmo - 2'd1;
        end
        S_WAIT_LO: begin
          state <= S_WAIT_LO;
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt <= GAP_W'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: instance 0 with checksum, instance 1 without.
// Each has a FIFO model and a behavioural core (busy 1 cycle after start, 10 cycles).
module tb_uart_tx_frame_ctrl;
  import cmd_pkg::*;

  localparam int NB = CMD_PKT_W / 8;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  cmd_packet_t fifo_mem [2][16];
  logic [3:0]  wr_ptr [2] = '{4'd0, 4'd0};
  logic [3:0]  rd_ptr [2] = '{4'd0, 4'd0};
  cmd_packet_t fifo_data [2];
  logic        fifo_valid [2];
  logic        rd_en [2];
  logic [7:0]  byte_data [2];
  logic        byte_start [2];
  logic        byte_busy [2];
  logic        dut_busy [2];
  logic [15:0] fs [2];
  int          core_cnt [2] = '{0, 0};
  bit          force_busy [2] = '{1'b0, 1'b0};
  bit          never_busy [2] = '{1'b0, 1'b0};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    uart_tx_if u_if ();
    assign fifo_valid[g] = (wr_ptr[g] != rd_ptr[g]);
    assign fifo_data[g]  = fifo_mem[g][rd_ptr[g]];
    assign byte_busy[g]  = force_busy[g] | (!never_busy[g] && core_cnt[g] != 0);
    assign u_if.byte_busy = byte_busy[g];
    assign byte_data[g]  = u_if.byte_data;
    assign byte_start[g] = u_if.byte_start;

    uart_tx_frame_ctrl #(
      .SOF_BYTE   (8'hA5),
      .GAP_CYCLES (16),
      .CHK_EN     ((g == 0) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cmd_fifo_rd_data (fifo_data[g]),
      .cmd_fifo_valid   (fifo_valid[g]),
      .cmd_fifo_rd_en   (rd_en[g]),
      .tx               (u_if),
      .busy             (dut_busy[g]),
      .frames_sent      (fs[g])
    );
  end

  // FIFO pop and core busy model.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rd_en[g]) rd_ptr[g] <= rd_ptr[g] + 4'd1;
      if (byte_start[g])         core_cnt[g] <= 10;
      else if (core_cnt[g] != 0) core_cnt[g] <= core_cnt[g] - 1;
    end
  end

  // Monitor: capture emitted bytes, pop timing and start spacing.
  int         cyc = 0;
  logic [7:0] got_mem [2][128];
  int         got_cnt [2]  = '{0, 0};
  int         rd_cnt [2]   = '{0, 0};
  int         rd_gap [2][16];
  int         last_fall [2] = '{0, 0};
  int         last_st [2]  = '{0, 0};
  int         st_gap [2]   = '{0, 0};
  int         pop_viol [2] = '{0, 0};
  logic       busy_prev [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      if (byte_start[g]) begin
        got_mem[g][got_cnt[g][6:0]] <= byte_data[g];
        got_cnt[g] <= got_cnt[g] + 1;
        st_gap[g]  <= cyc - last_st[g];
        last_st[g] <= cyc;
      end
      if (busy_prev[g] && !byte_busy[g]) last_fall[g] <= cyc;
      busy_prev[g] <= byte_busy[g];
      if (rd_en[g]) begin
        rd_cnt[g] <= rd_cnt[g] + 1;
        rd_gap[g][rd_cnt[g][3:0]] <= (busy_prev[g] && !byte_busy[g]) ? 0 : cyc - last_fall[g];
        if (dut_busy[g]) pop_viol[g] <= pop_viol[g] + 1;
      end
    end
  end

  // Scoreboard and counters.
  logic [7:0] exp_q [2][$];
  int         got_rd [2] = '{0, 0};
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int g, input cmd_packet_t p, input bit chk_en);
    logic [CMD_PKT_W-1:0] v;
    logic [7:0] c;
    v = p;
    c = 8'h00;
    fifo_mem[g][wr_ptr[g]] = p;
    wr_ptr[g] = wr_ptr[g] + 4'd1;
    exp_q[g].push_back(8'hA5);
    for (int i = NB - 1; i >= 0; i--) begin
      exp_q[g].push_back(v[i*8 +: 8]);
      c = c ^ v[i*8 +: 8];
    end
    if (chk_en) exp_q[g].push_back(c);
  endtask

  task automatic check_stream(input int g, input string tag);
    logic [7:0] e;
    while (got_rd[g] < got_cnt[g]) begin
      if (exp_q[g].size() > 0) e = exp_q[g].pop_front();
      else                     e = 8'hxx;
      check(tag, {24'd0, got_mem[g][got_rd[g][6:0]]}, {24'd0, e});
      got_rd[g]++;
    end
  endtask

  task automatic check_empty(input int g, input string tag);
    check(tag, exp_q[g].size(), 0);
  endtask

  task automatic wait_frames(input int g, input logic [15:0] target, input int budget);
    int n;
    n = 0;
    while (fs[g] !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frames_sent", {16'd0, fs[g]}, {16'd0, target});
  endtask

  task automatic wait_bytes(input int g, input int target, input int budget);
    int n;
    n = 0;
    while (got_cnt[g] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("byte_count_wait", got_cnt[g], target);
  endtask

  initial begin
    int rd0, st0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check("rst_byte_start", {31'd0, byte_start[g]}, 0);
      check("rst_byte_data",  {24'd0, byte_data[g]}, 0);
      check("rst_rd_en",      {31'd0, rd_en[g]}, 0);
      check("rst_busy",       {31'd0, dut_busy[g]}, 0);
      check("rst_frames",     {16'd0, fs[g]}, 0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single packet with checksum
    push_pkt(0, 48'h01_10_DEAD_BEEF, 1'b1);
    wait_frames(0, 16'd1, 400);
    check("t1_chk_byte", {24'd0, got_mem[0][7]}, 32'h33);
    check_stream(0, "t1_byte");
    check_empty(0, "t1_exp_left");
    check("t1_rd_pulses", rd_cnt[0], 1);
    check("t1_start_spacing", st_gap[0], 12);

    // 2: three packets back to back
    push_pkt(0, 48'h11_22_3344_5566, 1'b1);
    push_pkt(0, 48'hA0_0B_C0DE_F00D, 1'b1);
    push_pkt(0, 48'h00_00_0000_0001, 1'b1);
    wait_frames(0, 16'd4, 1500);
    check_stream(0, "t2_byte");
    check_empty(0, "t2_exp_left");
    check("t2_rd_pulses", rd_cnt[0], 4);
    for (int k = 1; k <= 3; k++)
      check("t2_pop_gap_ge17", {31'd0, rd_gap[0][k] >= 17}, 1);
    check("t2_pop_viol", pop_viol[0], 0);

    // 3: no checksum instance
    push_pkt(1, 48'hFFFF_FFFF_FFFF, 1'b0);
    wait_frames(1, 16'd1, 400);
    check("t3_byte_count", got_cnt[1], 7);
    check_stream(1, "t3_byte");
    check_empty(1, "t3_exp_left");

    // 4: core busy in IDLE blocks the pop
    repeat (20) @(posedge clk);
    #1;
    force_busy[0] = 1'b1;
    push_pkt(0, 48'h5A_A5_1234_5678, 1'b1);
    rd0 = rd_cnt[0];
    st0 = got_cnt[0];
    repeat (20) @(negedge clk);
    check("t4_no_pop", rd_cnt[0], rd0);
    check("t4_no_start", got_cnt[0], st0);
    @(posedge clk);
    #1;
    force_busy[0] = 1'b0;
    wait_frames(0, 16'd5, 400);
    check("t4_pop_on_fall", rd_gap[0][4], 0);
    check_stream(0, "t4_byte");
    check_empty(0, "t4_exp_left");

    // 5: reset during the third payload byte
    rd0 = rd_cnt[0];
    st0 = got_cnt[0];
    push_pkt(0, 48'hC3_3C_0F0F_F0F0, 1'b1);
    push_pkt(0, 48'h7E_81_2468_ACE0, 1'b1);
    wait_bytes(0, st0 + 4, 400);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_byte_start", {31'd0, byte_start[0]}, 0);
    check("t5_byte_data",  {24'd0, byte_data[0]}, 0);
    check("t5_rd_en",      {31'd0, rd_en[0]}, 0);
    check("t5_busy",       {31'd0, dut_busy[0]}, 0);
    check("t5_frames",     {16'd0, fs[0]}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_stream(0, "t5_partial");
    while (exp_q[0].size() > NB + 2) void'(exp_q[0].pop_front());
    wait_frames(0, 16'd1, 600);
    check_stream(0, "t5_byte");
    check_empty(0, "t5_exp_left");
    check("t5_no_replay", rd_cnt[0], rd0 + 2);

    // 6: core never raises busy
    never_busy[0] = 1'b1;
    st0 = got_cnt[0];
    push_pkt(0, 48'h99_88_7766_5544, 1'b1);
    wait_frames(0, 16'd2, 600);
    check("t6_start_pulses", got_cnt[0] - st0, NB + 2);
    check("t6_start_spacing", st_gap[0], 5);
    check_stream(0, "t6_byte");
    check_empty(0, "t6_exp_left");
    check("t6_pop_viol", pop_viol[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
